// File: rtl/slice_sequencer.sv
// rtl/slice_sequencer.sv - per-slice framebuffer burst sequencer with bank swap, blanking and overrun detection
module slice_sequencer #(
    parameter int N_SLICES        = 128,
    parameter int WORDS_PER_SLICE = 32,
    parameter int ADDR_W          = 12
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              position_sync,
    input  logic [7:0]        slice_cnt,
    input  logic              frame_ready,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    output logic              rd_bank,
    output logic              slice_start,
    output logic              slice_done,
    output logic              frame_swap,
    output logic              blank,
    output logic              overrun,
    output logic [7:0]        overrun_cnt
);

    localparam int                IDX_W      = (WORDS_PER_SLICE > 1) ? $clog2(WORDS_PER_SLICE) : 1;
    localparam logic [8:0]        N_SLICES_L = 9'(N_SLICES);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(WORDS_PER_SLICE - 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         slice_q, slice_d;
    logic [IDX_W-1:0]   word_idx_q, word_idx_d;
    logic               pending_q, pending_d;
    logic               rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               rd_bank_q, rd_bank_d;
    logic               slice_start_q, slice_start_d;
    logic               slice_done_q, slice_done_d;
    logic               frame_swap_q, frame_swap_d;
    logic               blank_q, blank_d;
    logic               overrun_q, overrun_d;
    logic [7:0]         overrun_cnt_q, overrun_cnt_d;

    logic               in_range;
    logic               last_xfer;
    logic               swap;

    // Classify the incoming sync and detect the final accepted word of a burst
    always_comb begin
        in_range  = ({1'b0, slice_cnt} < N_SLICES_L);
        last_xfer = (state_q == BURST) && rd_ack && (word_idx_q == LAST_IDX);
        swap      = position_sync && (slice_cnt == 8'd0) && pending_q;
    end

    // Next-state and registered-output logic; a sync takes priority over burst progress
    always_comb begin
        state_d       = state_q;
        slice_d       = slice_q;
        word_idx_d    = word_idx_q;
        rd_req_d      = rd_req_q;
        rd_bank_d     = rd_bank_q;
        blank_d       = blank_q;
        overrun_cnt_d = overrun_cnt_q;
        slice_start_d = 1'b0;
        slice_done_d  = 1'b0;
        frame_swap_d  = 1'b0;
        overrun_d     = 1'b0;
        pending_d     = (pending_q & ~swap) | frame_ready;

        if (position_sync) begin
            // A sync landing on the final accepted word completes that burst rather than aborting it
            if (last_xfer) begin
                slice_done_d = 1'b1;
            end else if (state_q == BURST) begin
                overrun_d     = 1'b1;
                overrun_cnt_d = (overrun_cnt_q == 8'hFF) ? 8'hFF : overrun_cnt_q + 8'd1;
            end

            if (!in_range) begin
                blank_d  = 1'b1;
                rd_req_d = 1'b0;
                state_d  = IDLE;
            end else begin
                blank_d       = 1'b0;
                slice_d       = slice_cnt;
                word_idx_d    = '0;
                rd_req_d      = 1'b1;
                slice_start_d = 1'b1;
                state_d       = BURST;
                if (swap) begin
                    rd_bank_d    = ~rd_bank_q;
                    frame_swap_d = 1'b1;
                end
            end
        end else if ((state_q == BURST) && rd_ack) begin
            if (last_xfer) begin
                rd_req_d     = 1'b0;
                slice_done_d = 1'b1;
                state_d      = IDLE;
            end else begin
                word_idx_d = word_idx_q + 1'b1;
            end
        end
    end

    // Word address of the next transfer, registered alongside rd_req
    always_comb begin
        rd_addr_d = ADDR_W'(slice_d) * ADDR_W'(WORDS_PER_SLICE) + ADDR_W'(word_idx_d);
    end

    // State and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q       <= IDLE;
            slice_q       <= '0;
            word_idx_q    <= '0;
            pending_q     <= 1'b0;
            rd_req_q      <= 1'b0;
            rd_addr_q     <= '0;
            rd_bank_q     <= 1'b0;
            slice_start_q <= 1'b0;
            slice_done_q  <= 1'b0;
            frame_swap_q  <= 1'b0;
            blank_q       <= 1'b1;
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            slice_q       <= slice_d;
            word_idx_q    <= word_idx_d;
            pending_q     <= pending_d;
            rd_req_q      <= rd_req_d;
            rd_addr_q     <= rd_addr_d;
            rd_bank_q     <= rd_bank_d;
            slice_start_q <= slice_start_d;
            slice_done_q  <= slice_done_d;
            frame_swap_q  <= frame_swap_d;
            blank_q       <= blank_d;
            overrun_q     <= overrun_d;
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign rd_req      = rd_req_q;
    assign rd_addr     = rd_addr_q;
    assign rd_bank     = rd_bank_q;
    assign slice_start = slice_start_q;
    assign slice_done  = slice_done_q;
    assign frame_swap  = frame_swap_q;
    assign blank       = blank_q;
    assign overrun     = overrun_q;
    assign overrun_cnt = overrun_cnt_q;

endmodule

// File: tb/tb_slice_sequencer.sv
// tb/tb_slice_sequencer.sv - scoreboard bench for slice_sequencer
module tb_slice_sequencer;

    logic        clk = 1'b0;
    logic        nrst;
    logic        position_sync;
    logic [7:0]  slice_cnt;
    logic        frame_ready;
    logic        rd_req;
    logic [11:0] rd_addr;
    logic        rd_ack;
    logic        rd_bank;
    logic        slice_start;
    logic        slice_done;
    logic        frame_swap;
    logic        blank;
    logic        overrun;
    logic [7:0]  overrun_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];

    slice_sequencer #(
        .N_SLICES(128),
        .WORDS_PER_SLICE(32),
        .ADDR_W(12)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .position_sync(position_sync),
        .slice_cnt(slice_cnt),
        .frame_ready(frame_ready),
        .rd_req(rd_req),
        .rd_addr(rd_addr),
        .rd_ack(rd_ack),
        .rd_bank(rd_bank),
        .slice_start(slice_start),
        .slice_done(slice_done),
        .frame_swap(frame_swap),
        .blank(blank),
        .overrun(overrun),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // Every transfer that the next posedge will perform must match the head of the expected queue
    always @(negedge clk) begin
        logic [11:0] e;
        if (nrst && rd_req && rd_ack) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected: rd_addr=%0d, required no transfer", rd_addr);
            end else begin
                e = exp_q.pop_front();
                if (rd_addr !== e) begin
                    errors++;
                    $display("FAIL xfer_addr: rd_addr=%0d, required %0d", rd_addr, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one sync; afterwards the DUT outputs for that sync are visible
    task automatic do_sync(input logic [7:0] cnt);
        position_sync = 1'b1;
        slice_cnt     = cnt;
        @(posedge clk);
        #1;
        position_sync = 1'b0;
        exp_q.delete();
        if (cnt < 8'd128) begin
            for (int i = 0; i < 32; i++) exp_q.push_back(12'(int'(cnt) * 32 + i));
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (slice_done) return;
        end
        n = -1;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({rd_req, rd_bank, slice_start, slice_done, frame_swap, overrun} !== 6'b0 || blank !== 1'b1 ||
            overrun_cnt !== 8'd0 || rd_addr !== 12'd0) begin
            errors++;
            $display("FAIL reset_state: req=%b bank=%b start=%b done=%b swap=%b ovr=%b blank=%b cnt=%0d addr=%0d, required all 0 except blank=1",
                     rd_req, rd_bank, slice_start, slice_done, frame_swap, overrun, blank, overrun_cnt, rd_addr);
        end
        @(posedge clk);
        #1;
        nrst = 1'b1;
        step(2);
    endtask

    task automatic test_nominal;
        int n;
        rd_ack = 1'b1;
        do_sync(8'd5);
        checks++;
        if (slice_start !== 1'b1 || rd_req !== 1'b1 || rd_addr !== 12'd160 || blank !== 1'b0) begin
            errors++;
            $display("FAIL nominal_start: start=%b req=%b addr=%0d blank=%b, required 1 1 160 0",
                     slice_start, rd_req, rd_addr, blank);
        end
        wait_done(n);
        checks++;
        if (n !== 32 || rd_req !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL nominal_done: cycles=%0d req=%b left=%0d, required 32 0 0", n, rd_req, exp_q.size());
        end
        step(1);
        checks++;
        if (slice_done !== 1'b0) begin
            errors++;
            $display("FAIL nominal_done_pulse: slice_done=%b, required 0", slice_done);
        end
    endtask

    task automatic test_backpressure;
        int          n;
        logic [11:0] prev;
        logic        prev_ack;
        rd_ack = 1'b0;
        do_sync(8'd0);
        checks++;
        if (frame_swap !== 1'b0 || rd_addr !== 12'd0) begin
            errors++;
            $display("FAIL bp_start: swap=%b addr=%0d, required 0 0", frame_swap, rd_addr);
        end
        n = 0;
        while (n < 200) begin
            rd_ack   = n[0];
            prev     = rd_addr;
            prev_ack = rd_ack;
            @(posedge clk);
            #1;
            n++;
            if (!prev_ack && !slice_done) begin
                checks++;
                if (rd_addr !== prev) begin
                    errors++;
                    $display("FAIL bp_hold: rd_addr=%0d, required %0d", rd_addr, prev);
                end
            end
            if (slice_done) break;
        end
        rd_ack = 1'b0;
        checks++;
        if (n !== 64 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bp_done: cycles=%0d left=%0d, required 64 0", n, exp_q.size());
        end
    endtask

    task automatic test_overrun;
        int n;
        rd_ack = 1'b1;
        do_sync(8'd3);
        step(10);
        do_sync(8'd4);
        checks++;
        if (overrun !== 1'b1 || overrun_cnt !== 8'd1 || slice_done !== 1'b0 || rd_addr !== 12'd128 ||
            slice_start !== 1'b1) begin
            errors++;
            $display("FAIL overrun_first: ovr=%b cnt=%0d done=%b addr=%0d start=%b, required 1 1 0 128 1",
                     overrun, overrun_cnt, slice_done, rd_addr, slice_start);
        end
        step(1);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_pulse: overrun=%b, required 0", overrun);
        end
        for (int i = 0; i < 300; i++) begin
            do_sync((i % 2 == 0) ? 8'd3 : 8'd4);
            step(1);
        end
        checks++;
        if (overrun_cnt !== 8'd255) begin
            errors++;
            $display("FAIL overrun_sat: overrun_cnt=%0d, required 255", overrun_cnt);
        end
        wait_done(n);
        checks++;
        if (n < 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL overrun_drain: cycles=%0d left=%0d, required done and 0", n, exp_q.size());
        end
    endtask

    task automatic test_bank_swap;
        int n;
        rd_ack      = 1'b1;
        frame_ready = 1'b1;
        step(1);
        frame_ready = 1'b0;
        do_sync(8'd7);
        checks++;
        if (frame_swap !== 1'b0 || rd_bank !== 1'b0 || slice_start !== 1'b1) begin
            errors++;
            $display("FAIL swap_nonzero: swap=%b bank=%b start=%b, required 0 0 1", frame_swap, rd_bank, slice_start);
        end
        wait_done(n);
        do_sync(8'd0);
        checks++;
        if (frame_swap !== 1'b1 || slice_start !== 1'b1 || rd_bank !== 1'b1) begin
            errors++;
            $display("FAIL swap_zero: swap=%b start=%b bank=%b, required 1 1 1", frame_swap, slice_start, rd_bank);
        end
        wait_done(n);
        do_sync(8'd0);
        checks++;
        if (frame_swap !== 1'b0 || rd_bank !== 1'b1) begin
            errors++;
            $display("FAIL swap_unarmed: swap=%b bank=%b, required 0 1", frame_swap, rd_bank);
        end
        wait_done(n);
        frame_ready = 1'b1;
        step(1);
        do_sync(8'd0);
        frame_ready = 1'b0;
        checks++;
        if (frame_swap !== 1'b1 || rd_bank !== 1'b0) begin
            errors++;
            $display("FAIL swap_rearm_first: swap=%b bank=%b, required 1 0", frame_swap, rd_bank);
        end
        wait_done(n);
        do_sync(8'd0);
        checks++;
        if (frame_swap !== 1'b1 || rd_bank !== 1'b1) begin
            errors++;
            $display("FAIL swap_rearm_second: swap=%b bank=%b, required 1 1", frame_swap, rd_bank);
        end
        wait_done(n);
        checks++;
        if (n < 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL swap_drain: cycles=%0d left=%0d, required done and 0", n, exp_q.size());
        end
    endtask

    task automatic test_blanking;
        int n;
        rd_ack = 1'b1;
        do_sync(8'd130);
        checks++;
        if (blank !== 1'b1 || rd_req !== 1'b0 || slice_start !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL blank_set: blank=%b req=%b start=%b ovr=%b, required 1 0 0 0", blank, rd_req, slice_start, overrun);
        end
        step(3);
        checks++;
        if (blank !== 1'b1 || rd_req !== 1'b0) begin
            errors++;
            $display("FAIL blank_hold: blank=%b req=%b, required 1 0", blank, rd_req);
        end
        do_sync(8'd0);
        checks++;
        if (blank !== 1'b0 || rd_req !== 1'b1 || rd_addr !== 12'd0 || slice_start !== 1'b1) begin
            errors++;
            $display("FAIL blank_clear: blank=%b req=%b addr=%0d start=%b, required 0 1 0 1", blank, rd_req, rd_addr, slice_start);
        end
        wait_done(n);
        checks++;
        if (n !== 32 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL blank_burst: cycles=%0d left=%0d, required 32 0", n, exp_q.size());
        end
    endtask

    task automatic test_simultaneous;
        rd_ack = 1'b1;
        do_sync(8'd2);
        step(31);
        do_sync(8'd9);
        checks++;
        if (slice_done !== 1'b1 || overrun !== 1'b0 || slice_start !== 1'b1 || rd_addr !== 12'd288 || rd_req !== 1'b1) begin
            errors++;
            $display("FAIL simul_sync_last: done=%b ovr=%b start=%b addr=%0d req=%b, required 1 0 1 288 1",
                     slice_done, overrun, slice_start, rd_addr, rd_req);
        end
        step(3);
        frame_ready = 1'b1;
        step(1);
        frame_ready = 1'b0;
        #2;
        nrst = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (rd_req !== 1'b0 || blank !== 1'b1 || overrun_cnt !== 8'd0 || rd_bank !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: req=%b blank=%b cnt=%0d bank=%b, required 0 1 0 0", rd_req, blank, overrun_cnt, rd_bank);
        end
        @(posedge clk);
        #1;
        nrst = 1'b1;
        step(1);
        do_sync(8'd0);
        checks++;
        if (frame_swap !== 1'b0 || rd_bank !== 1'b0 || slice_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_pending_lost: swap=%b bank=%b start=%b, required 0 0 1", frame_swap, rd_bank, slice_start);
        end
    endtask

    initial begin
        nrst          = 1'b0;
        position_sync = 1'b0;
        slice_cnt     = 8'd0;
        frame_ready   = 1'b0;
        rd_ack        = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_overrun();
        test_bank_swap();
        test_blanking();
        test_simultaneous();
        step(40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/slice_sequencer.md
# slice_sequencer

Sequences framebuffer readout for the rotating display, one burst per angular slice. Consumes the per-slice `position_sync` pulse and `slice_cnt` index produced by the Hall-sensor slice timer. For each valid slice it issues a burst of word reads to the framebuffer read port over a req/ack handshake. It also manages double-buffer bank swapping at the top of each half-turn, blanks out-of-range slices, and detects slice overruns.

## Interface

- `N_SLICES`, 128: valid slices per half-turn; indices `>= N_SLICES` are blanked.
- `WORDS_PER_SLICE`, 32: words read per slice burst.
- `ADDR_W`, 12: `rd_addr` width; `N_SLICES*WORDS_PER_SLICE <= 2**ADDR_W`.
- `clk`  in  1  system clock.
- `nrst`  in  1  asynchronous, active-low reset.
- `position_sync`  in  1  one-cycle pulse at the start of each slice.
- `slice_cnt`  in  8  slice index, valid when `position_sync` is high.
- `frame_ready`  in  1  one-cycle pulse; writer has finished filling the back bank.
- `rd_req`  out  1  read request, held until the burst ends or is aborted.
- `rd_addr`  out  ADDR_W  word address within the bank, valid while `rd_req` is high.
- `rd_ack`  in  1  a word transfers on any cycle with `rd_req && rd_ack`.
- `rd_bank`  out  1  front (display) bank select.
- `slice_start`  out  1  one-cycle pulse; a burst begins.
- `slice_done`  out  1  one-cycle pulse; the last word of a burst was accepted.
- `frame_swap`  out  1  one-cycle pulse; `rd_bank` toggled.
- `blank`  out  1  current slice is out of range; the LED drivers must output dark.
- `overrun`  out  1  one-cycle pulse; a burst was aborted by a new `position_sync`.
- `overrun_cnt`  out  8  saturating count of overruns since reset.

## Operation

- **State machine.** Two states, IDLE and BURST. Internal registers:
  - `slice_q` (8 bits)
  - `word_idx` (`$clog2(WORDS_PER_SLICE)` bits)
  - `pending` (1 bit): a frame is ready and awaiting a swap.
- **Address.** `rd_addr = slice_q*WORDS_PER_SLICE + word_idx`, truncated to `ADDR_W` bits.
- **Sync handling.** A `position_sync` ("sync") is processed identically in IDLE and BURST.
  - If `slice_cnt >= N_SLICES`:
    - `blank <= 1` and `rd_req <= 0`.
    - Next state is IDLE.
    - No `slice_start` is issued.
  - Otherwise:
    - `blank <= 0`, `slice_q <= slice_cnt`, `word_idx <= 0`.
    - `rd_req <= 1` and `slice_start` pulses.
    - Next state is BURST.
- **Bank swap.** A swap occurs on a sync with `slice_cnt == 0` and `pending == 1`. On a swap:
  - `rd_bank` toggles.
  - `frame_swap` pulses in the same cycle as `slice_start`.
- **Pending update.** Each cycle, `pending <= (pending & ~swap) | frame_ready`.
  - A `frame_ready` coinciding with a swap therefore arms the next swap.
  - Multiple `frame_ready` pulses before a swap collapse into one.
- **BURST without a sync.** On each cycle with `rd_ack` high:
  - If `word_idx == WORDS_PER_SLICE-1`: `rd_req <= 0`, `slice_done` pulses, next state is IDLE.
  - Otherwise `word_idx` increments.
  - With `rd_ack` low, all state holds and `rd_addr` stays stable.
- **Overrun.** A sync arriving while in BURST aborts the current burst:
  - `overrun` pulses and `overrun_cnt` increments, saturating at 255.
  - No `slice_done` is issued for the aborted burst.
  - The sync is handled as above in the same cycle.
- **Sync coinciding with the last accepted word.** The burst counts as complete:
  - `slice_done` pulses and there is no overrun.
  - The new sync is handled normally.
- **Blanking.** `blank` stays set until the next in-range sync.

## Timing

- **Reset values.** State IDLE, `blank = 1`, `pending = 0`; every other output is 0.
- All outputs are registered.
- **Sync latency.** `slice_start`, `frame_swap`, `rd_req`, `rd_addr` and `blank` update on the first clock edge that samples `position_sync` high. They are visible one cycle after the sync.
- **Burst length.** With `rd_ack` tied high, a burst occupies exactly `WORDS_PER_SLICE` cycles of `rd_req`.
  - `slice_done` is visible the cycle after the last transfer, coincident with `rd_req` low.
- **Handshake.** `rd_req` never drops without either a completed final transfer or an abort.
- **Reset mid-burst.** Reset is asynchronous: `rd_req` clears immediately and `pending` is lost.

## Test plan

- **Nominal burst.** Reset; sync with `slice_cnt = 5`, `rd_ack` = 1.
  - Expect `slice_start` 1 cycle later.
  - Expect `rd_addr` 160..191 over 32 cycles, then a `slice_done` pulse and `rd_req` = 0.
- **Back-pressure.** Sync `slice_cnt = 0`; toggle `rd_ack` every other cycle.
  - Expect `rd_addr` held when `rd_ack` = 0 and each of addresses 0..31 transferred exactly once.
  - Expect `slice_done` after 64 cycles.
- **Overrun.** Sync `slice_cnt = 3`; `rd_ack` high for 10 cycles; then sync `slice_cnt = 4`.
  - Expect an `overrun` pulse, `overrun_cnt` = 1, no `slice_done`.
  - Expect `rd_addr` to restart at 128.
  - Repeat 300 times; expect `overrun_cnt` = 255.
- **Bank swap.** `frame_ready` pulse, then sync `slice_cnt = 7`.
  - Expect no swap.
  - Next sync `slice_cnt = 0`: expect `frame_swap` with `slice_start` and `rd_bank` 0→1.
  - Another sync `slice_cnt = 0` without `frame_ready`: expect no swap.
- **Blanking.** Sync `slice_cnt = 130`.
  - Expect `blank` = 1, `rd_req` = 0, no `slice_start`.
  - Sync `slice_cnt = 0`: expect `blank` = 0 and a burst starting at `rd_addr` 0.
- **Simultaneous events.** Sync coincides with the ack of word 31.
  - Expect a `slice_done` pulse, no `overrun`, and the new burst starting.
  - Assert `nrst` mid-burst: expect immediate `rd_req` = 0 and `blank` = 1.
